// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, column/row counters, registered sync/blank
// decode, a look-ahead fetch position and a start/stop control that acts on frame boundaries.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int PIX_DIV  = 2,
   parameter int LEAD     = 2,
   parameter int COL_W    = 10,
   parameter int ROW_W    = 9,
   parameter int FRAME_W  = 8
) (
   input  logic               clk,
   input  logic               rstN,
   input  logic               run,
   output logic               hSync,
   output logic               vSync,
   output logic               displayActive,
   output logic [COL_W-1:0]   column,
   output logic [ROW_W-1:0]   row,
   output logic [COL_W-1:0]   fetchColumn,
   output logic [ROW_W-1:0]   fetchRow,
   output logic               fetchActive,
   output logic               pixTick,
   output logic               lineStart,
   output logic               frameStart,
   output logic [FRAME_W-1:0] frameCount,
   output logic               busy,
   output logic [1:0]         dbgState
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic H_ON  = (H_POL != 0);
   localparam logic V_ON  = (V_POL != 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   function automatic logic f_visible(input int c, input int r);
      return (c < H_ACTIVE) && (r < V_ACTIVE);
   endfunction

   function automatic logic f_hsync(input int c);
      return ((c >= H_ACTIVE + H_FP) && (c < H_ACTIVE + H_FP + H_SYNC)) ? H_ON : ~H_ON;
   endfunction

   function automatic logic f_vsync(input int r);
      return ((r >= V_ACTIVE + V_FP) && (r < V_ACTIVE + V_FP + V_SYNC)) ? V_ON : ~V_ON;
   endfunction

   state_t             r_state;
   logic [DIV_W-1:0]   r_div;
   logic [COL_W-1:0]   r_col;
   logic [ROW_W-1:0]   r_row;
   logic               r_hsync, r_vsync, r_disp;
   logic [COL_W-1:0]   r_fcol;
   logic [ROW_W-1:0]   r_frow;
   logic               r_fact;
   logic               r_pix_tick, r_line_start, r_frame_start, r_busy;
   logic [FRAME_W-1:0] r_frame_count;

   state_t             w_nstate;
   logic [DIV_W-1:0]   w_ndiv;
   logic [COL_W-1:0]   w_ncol;
   logic [ROW_W-1:0]   w_nrow;
   logic               w_tick, w_col_last, w_row_last, w_wrap, w_going;
   int                 w_fcol_i, w_frow_i;

   assign w_tick     = (r_state != S_IDLE) && (r_div == DIV_W'(PIX_DIV - 1));
   assign w_col_last = (r_col == COL_W'(H_TOTAL - 1));
   assign w_row_last = (r_row == ROW_W'(V_TOTAL - 1));
   assign w_wrap     = w_tick && w_col_last && w_row_last;
   assign w_going    = (w_nstate != S_IDLE);

   // Next counter values; every registered output decodes these so it has no lag.
   always_comb begin
      w_nstate = r_state;
      w_ndiv   = r_div;
      w_ncol   = r_col;
      w_nrow   = r_row;
      case (r_state)
         S_IDLE: begin
            w_ndiv = '0;
            w_ncol = '0;
            w_nrow = '0;
            if (run) w_nstate = S_RUN;
         end
         default: begin
            if (w_tick) begin
               w_ndiv = '0;
               if (w_col_last) begin
                  w_ncol = '0;
                  w_nrow = w_row_last ? '0 : r_row + ROW_W'(1);
               end else begin
                  w_ncol = r_col + COL_W'(1);
               end
            end else begin
               w_ndiv = r_div + DIV_W'(1);
            end
            // A dropped run only takes effect once the current frame has fully wrapped.
            if (w_wrap && !run) w_nstate = S_IDLE;
            else                w_nstate = run ? S_RUN : S_DRAIN;
         end
      endcase
   end

   always_comb begin
      w_fcol_i = int'(w_ncol) + LEAD;
      w_frow_i = int'(w_nrow);
      if (w_fcol_i >= H_TOTAL) begin
         w_fcol_i = w_fcol_i - H_TOTAL;
         w_frow_i = (w_frow_i == V_TOTAL - 1) ? 0 : w_frow_i + 1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         r_state       <= S_IDLE;
         r_div         <= '0;
         r_col         <= '0;
         r_row         <= '0;
         r_hsync       <= ~H_ON;
         r_vsync       <= ~V_ON;
         r_disp        <= 1'b0;
         r_fcol        <= COL_W'(LEAD);
         r_frow        <= '0;
         r_fact        <= f_visible(LEAD, 0);
         r_pix_tick    <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_busy        <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_state       <= w_nstate;
         r_div         <= w_ndiv;
         r_col         <= w_ncol;
         r_row         <= w_nrow;
         r_hsync       <= w_going ? f_hsync(int'(w_ncol)) : ~H_ON;
         r_vsync       <= w_going ? f_vsync(int'(w_nrow)) : ~V_ON;
         r_disp        <= w_going && f_visible(int'(w_ncol), int'(w_nrow));
         r_fcol        <= COL_W'(w_fcol_i);
         r_frow        <= ROW_W'(w_frow_i);
         r_fact        <= f_visible(w_fcol_i, w_frow_i);
         r_pix_tick    <= w_tick;
         r_line_start  <= w_tick && w_col_last;
         r_frame_start <= ((r_state == S_IDLE) && run) || (w_wrap && run);
         r_busy        <= w_going;
         r_frame_count <= r_frame_count + FRAME_W'(w_wrap);
      end
   end

   assign hSync         = r_hsync;
   assign vSync         = r_vsync;
   assign displayActive = r_disp;
   assign column        = r_col;
   assign row           = r_row;
   assign fetchColumn   = r_fcol;
   assign fetchRow      = r_frow;
   assign fetchActive   = r_fact;
   assign pixTick       = r_pix_tick;
   assign lineStart     = r_line_start;
   assign frameStart    = r_frame_start;
   assign frameCount    = r_frame_count;
   assign busy          = r_busy;
   assign dbgState      = r_state;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a tiny 7x5 raster: linear-pixel-index reference model checked
// every clock, a table of phases with hand-derived end states, a corner sequence, random bursts.
module tb_vga_timing_gen;

   localparam int HA = 4, HF = 1, HS = 1, HB = 1;
   localparam int VA = 2, VF = 1, VS = 1, VB = 1;
   localparam int PD = 2, LD = 2, HP = 1, VP = 0;
   localparam int CW = 10, RW = 9, FW = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME_CLK = HT * VT * PD;

   logic          clk, rstN, run;
   logic          hSync, vSync, displayActive, fetchActive;
   logic [CW-1:0] column, fetchColumn;
   logic [RW-1:0] row, fetchRow;
   logic          pixTick, lineStart, frameStart, busy;
   logic [FW-1:0] frameCount;
   logic [1:0]    dbgState;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_POL(HP), .V_POL(VP), .PIX_DIV(PD), .LEAD(LD),
      .COL_W(CW), .ROW_W(RW), .FRAME_W(FW)
   ) dut (
      .clk(clk), .rstN(rstN), .run(run),
      .hSync(hSync), .vSync(vSync), .displayActive(displayActive),
      .column(column), .row(row),
      .fetchColumn(fetchColumn), .fetchRow(fetchRow), .fetchActive(fetchActive),
      .pixTick(pixTick), .lineStart(lineStart), .frameStart(frameStart),
      .frameCount(frameCount), .busy(busy), .dbgState(dbgState)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: clocks elapsed since the start edge, plus frame bookkeeping
   bit m_busy = 0;
   int m_t    = 0;
   int m_fc   = 0;
   bit m_fs   = 0;
   bit m_iw   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit rn);
      m_fs = 0;
      m_iw = 0;
      if (!r) begin
         m_busy = 0; m_t = 0; m_fc = 0;
      end else if (!m_busy) begin
         if (rn) begin m_busy = 1; m_t = 0; m_fs = 1; end
      end else begin
         m_t++;
         if (m_t % FRAME_CLK == 0) begin
            m_fc = (m_fc + 1) % (1 << FW);
            if (!rn) begin m_busy = 0; m_iw = 1; end
            else m_fs = 1;
         end
      end
   endtask

   task automatic check_model();
      int p, col, rw, q, fc, fr;
      bit tick, hs, vs;
      p    = m_busy ? (m_t / PD) % (HT * VT) : 0;
      col  = p % HT;
      rw   = p / HT;
      tick = (m_busy && m_t > 0 && m_t % PD == 0) || m_iw;
      q    = (p + LD) % (HT * VT);
      fc   = q % HT;
      fr   = q / HT;
      hs   = (m_busy && col >= HA + HF && col < HA + HF + HS) ? HP[0] : !HP[0];
      vs   = (m_busy && rw >= VA + VF && rw < VA + VF + VS) ? VP[0] : !VP[0];
      check("column", column, col);
      check("row", row, rw);
      check("displayActive", displayActive, int'(m_busy && col < HA && rw < VA));
      check("hSync", hSync, hs);
      check("vSync", vSync, vs);
      check("fetchColumn", fetchColumn, fc);
      check("fetchRow", fetchRow, fr);
      check("fetchActive", fetchActive, int'(fc < HA && fr < VA));
      check("pixTick", pixTick, tick);
      check("lineStart", lineStart, int'(tick && col == 0));
      check("frameStart", frameStart, m_fs);
      check("frameCount", frameCount, m_fc);
      check("busy", busy, m_busy);
   endtask

   // driver: inputs change on the falling edge, outputs checked 1 ns after the rising edge
   task automatic step(input bit r, input bit rn);
      @(negedge clk);
      rstN = r;
      run  = rn;
      @(posedge clk);
      model_edge(r, rn);
      #1;
      check_model();
   endtask

   typedef struct {
      bit rst_n;
      bit run;
      int cycles;
      bit exp_busy;
      int exp_fc;
   } vec_t;

   vec_t vecs[$];

   initial begin
      rstN = 1'b0;
      run  = 1'b0;

      vecs.push_back('{0, 0,   2, 0, 0});  // reset
      vecs.push_back('{1, 1,   1, 1, 0});  // start edge
      vecs.push_back('{1, 1,  69, 1, 0});  // one clock before first wrap
      vecs.push_back('{1, 1,   1, 1, 1});  // wrap while running
      vecs.push_back('{1, 0,   1, 1, 1});  // drop run: drain
      vecs.push_back('{1, 0,  68, 1, 1});
      vecs.push_back('{1, 0,   1, 0, 2});  // drain completes at the wrap
      vecs.push_back('{1, 0,   5, 0, 2});
      vecs.push_back('{1, 1,   1, 1, 2});  // restart
      vecs.push_back('{1, 0,  20, 1, 2});  // drop mid-frame
      vecs.push_back('{1, 1,  30, 1, 2});  // re-raise: no return to idle
      vecs.push_back('{1, 0,  20, 0, 3});  // drop again, idles at wrap
      vecs.push_back('{1, 1,   1, 1, 3});
      vecs.push_back('{1, 1, 140, 1, 1});  // two frames: 3 -> 0 -> 1
      vecs.push_back('{0, 1,   1, 0, 0});  // reset mid-frame aborts
      vecs.push_back('{1, 0,   3, 0, 0});
      vecs.push_back('{1, 1,   1, 1, 0});  // one-clock run pulse
      vecs.push_back('{1, 0,  70, 0, 1});  // exactly one frame emitted
      vecs.push_back('{1, 0,   3, 0, 1});

      foreach (vecs[i]) begin
         repeat (vecs[i].cycles) step(vecs[i].rst_n, vecs[i].run);
         check($sformatf("tbl%0d_busy", i), busy, vecs[i].exp_busy);
         check($sformatf("tbl%0d_frameCount", i), frameCount, vecs[i].exp_fc);
      end

      // start edge, then the fetch wrap at the last pixel of the frame
      step(1, 1);
      check("start_frameStart", frameStart, 1);
      check("start_display", displayActive, 1);
      check("start_column", column, 0);
      repeat (68) step(1, 1);
      check("last_column", column, 6);
      check("last_row", row, 4);
      check("wrap_fetchColumn", fetchColumn, 1);
      check("wrap_fetchRow", fetchRow, 0);
      check("wrap_fetchActive", fetchActive, 1);
      step(1, 0);
      step(1, 0);
      check("drained_busy", busy, 0);
      check("drained_hSync", hSync, 0);
      check("drained_vSync", vSync, 1);
      check("drained_frameCount", frameCount, 2);

      // random bursts of run high/low with rare resets
      for (int b = 0; b < 24; b++) begin
         bit rv;
         int len;
         rv  = ($urandom_range(0, 3) != 0);
         len = $urandom_range(1, 90);
         for (int c = 0; c < len; c++)
            step(($urandom_range(0, 199) != 0), rv);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the successor to the fixed 640x480 `VgaController`. It produces sync, blanking, and pixel coordinates from the system clock using an internal pixel-rate divider. It also provides a look-ahead fetch coordinate so pipelined color generators (Game of Life, future framebuffer reader) can fetch ahead of the raster, plus frame/line strobes, a frame counter, and a start/stop control that only acts on frame boundaries.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal front porch, sync, back porch (pixels)
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical front porch, sync, back porch (lines)
- `H_POL`, 0 / `V_POL`, 0: asserted sync level (0 = active-low)
- `PIX_DIV`, 2: clk cycles per pixel, ≥1
- `LEAD`, 2: fetch look-ahead in pixels, 0 ≤ LEAD < H_TOTAL
- `COL_W`, 10 / `ROW_W`, 9 / `FRAME_W`, 8: coordinate and frame counter widths
- `clk  in  1`: system clock; all logic on the rising edge
- `rstN  in  1`: reset, **synchronous, active-low**
- `run  in  1`: request raster output
- `hSync  out  1` / `vSync  out  1`: sync outputs
- `displayActive  out  1`: current pixel is visible
- `column  out  COL_W` / `row  out  ROW_W`: current pixel position (the raw counters, including blanking)
- `fetchColumn  out  COL_W` / `fetchRow  out  ROW_W` / `fetchActive  out  1`: position LEAD pixels ahead
- `pixTick  out  1`: one-clk pulse on each pixel advance
- `lineStart  out  1` / `frameStart  out  1`: one-clk pulses when column becomes 0 / column and row both become 0
- `frameCount  out  FRAME_W`: completed frames, wraps modulo 2^FRAME_W
- `busy  out  1`: state ≠ IDLE

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Column counts 0..H_TOTAL-1, row counts 0..V_TOTAL-1. Both wrap.
- Divider: counts 0..PIX_DIV-1. The tick fires when the count is PIX_DIV-1, and the counter is held at 0 in IDLE. With PIX_DIV=1 the tick fires every clk.
- On each tick, column increments. At H_TOTAL-1, column wraps to 0 and row increments. At row V_TOTAL-1 with column H_TOTAL-1, the raster wraps to (0,0).
- Decode rules (all outputs registered, and they describe the counter value that holds after the same edge, with zero lag):
  - `displayActive` = column < H_ACTIVE && row < V_ACTIVE.
  - `hSync` = H_POL when H_ACTIVE+H_FP ≤ column < H_ACTIVE+H_FP+H_SYNC, else !H_POL. `vSync` follows the same rule on row.
- Fetch position = (column+LEAD) mod H_TOTAL, with the row incremented (mod V_TOTAL) on wrap. `fetchActive` uses the same decode as `displayActive`. The fetch outputs are valid in every state, including IDLE, so a generator can prime its first pixels.
- State machine:
  - **IDLE**: counters parked at (0,0), syncs inactive, `displayActive`=0, no ticks. Moves to RUN when `run`=1.
  - **RUN**: free-running raster. Moves to DRAIN when `run`=0.
  - **DRAIN**: raster continues. `run`=1 returns to RUN with no disturbance. When the frame wraps to (0,0), the block enters IDLE instead of starting a new frame. `frameCount` increments on that wrap, and `frameStart` does not pulse.
- `frameCount` increments on every (V_TOTAL-1,H_TOTAL-1)→(0,0) wrap.
- `frameStart` pulses on the IDLE→RUN start edge and on every wrap taken while in RUN.

## Timing
- Reset (`rstN`=0 at an edge): IDLE, all counters 0, `hSync`=!H_POL, `vSync`=!V_POL, all pulses and `displayActive`/`busy` 0. The fetch outputs show (0,0)+LEAD. Reset mid-line aborts immediately, with no drain.
- Start latency:
  - The edge sampling `run`=1 in IDLE sets `busy`=1 and `frameStart`=1.
  - `displayActive`=1 at that same edge, because (0,0) is visible.
  - The first `pixTick` occurs PIX_DIV edges later, and column=1 at that edge.
- Column period is PIX_DIV clk cycles. The line is H_TOTAL×PIX_DIV clk cycles, and the frame is V_TOTAL×H_TOTAL×PIX_DIV clk cycles.
- `lineStart` coincides with the `pixTick` that wraps column. `frameStart` coincides with the `lineStart` that wraps row.
- `run` is sampled every clk. Toggling `run` inside a frame never truncates the frame.

## Test plan
- Defaults, `run`=1 from reset:
  - `hSync` low for exactly 192 clk per line.
  - `hSync` falls 1312 clk after column 0.
  - The line is 1600 clk.
  - `vSync` low for 2 lines.
  - `frameStart` spacing is 840000 clk.
- PIX_DIV=1, H=4/1/1/1, V=2/1/1/1, LEAD=2, H_POL=V_POL=1:
  - The column sequence is 0..6 and wraps, with one tick per clk.
  - `hSync`=1 only at column 5.
  - `fetchColumn`=(column+2) mod 7.
  - At column 6 of row 4, the fetch position is (1,0) with `fetchActive`=1.
- `run` pulsed for one clk:
  - Exactly one full frame is emitted, then `busy`=0 with syncs inactive.
  - `frameCount` reads 1 afterwards, and only one `frameStart` pulse occurs.
- `run` dropped at row 100 and re-raised at row 200: the raster is uninterrupted and there is no return to IDLE.
- `rstN` low for one clk at row 300, column 400: next edge shows IDLE, (0,0), syncs inactive, `frameCount`=0.
- FRAME_W=2: five frames give the `frameCount` sequence 1,2,3,0,1.
